// File: rtl/bus8_autoclear_initiator.sv
// bus8_autoclear_initiator: Bus8 master for single write/read and run-and-wait polling; BUS8_AUTOCLEAR_HIST_CLEAR_EN adds a history clear
module bus8_autoclear_initiator #(
  parameter int RD_TIMEOUT = 16,
  parameter int POLL_GAP = 8,
  parameter int MAX_POLLS = 255
) (
  input  logic       i_Bus_Clk,
  input  logic       i_Bus_Rst,
  input  logic       i_Cmd_DV,
  output logic       o_Cmd_Ready,
  input  logic [1:0] i_Cmd_Op,
  input  logic [2:0] i_Cmd_Addr,
  input  logic [7:0] i_Cmd_Data,
  output logic       o_Rsp_DV,
  output logic [7:0] o_Rsp_Data,
  output logic       o_Rsp_Err,
  output logic       o_Bus_CS,
  output logic       o_Bus_Wr_Rd_n,
  output logic [2:0] o_Bus_Addr8,
  output logic [7:0] o_Bus_Wr_Data,
  input  logic [7:0] i_Bus_Rd_Data,
  input  logic       i_Bus_Rd_DV
);
  localparam int CMAX = RD_TIMEOUT > POLL_GAP ? RD_TIMEOUT : POLL_GAP;
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam logic [CW-1:0] T_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] G_LAST = CW'(POLL_GAP - 1);
  localparam logic [PW-1:0] P_LAST = PW'(MAX_POLLS - 1);
  typedef enum logic [3:0] {
    IDLE, WR, RD, RD_WAIT, RUN_START, GAP, POLL, POLL_WAIT, STOP, RESP
`ifdef BUS8_AUTOCLEAR_HIST_CLEAR_EN
    , HCLR
`endif
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d, stat_q, stat_d, rsp_data_q, rsp_data_d;
  logic rsp_err_q, rsp_err_d, wr, hclr;
`ifdef BUS8_AUTOCLEAR_HIST_CLEAR_EN
  assign hclr = state_q == HCLR;
`else
  assign hclr = 1'b0;
`endif
  // Sequencing: command capture, read/poll timeouts, poll accounting and response latching
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    stat_d = stat_q;
    pcnt_d = pcnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (i_Cmd_DV) begin
        addr_d = i_Cmd_Addr;
        data_d = i_Cmd_Data;
        pcnt_d = '0;
        state_d = i_Cmd_Op == 2'b00 ? WR : i_Cmd_Op == 2'b01 ? RD : i_Cmd_Op == 2'b10 ? RUN_START : RESP;
        if (i_Cmd_Op == 2'b11) begin
          rsp_data_d = 8'h00;
          rsp_err_d = 1'b1;
        end
      end
      WR: begin
        state_d = RESP;
        rsp_data_d = 8'h00;
        rsp_err_d = 1'b0;
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: if (i_Bus_Rd_DV || cnt_q == T_LAST) begin
        state_d = RESP;
        rsp_data_d = i_Bus_Rd_DV ? i_Bus_Rd_Data : 8'h00;
        rsp_err_d = !i_Bus_Rd_DV;
      end
      RUN_START: state_d = GAP;
      GAP: if (cnt_q == G_LAST) state_d = POLL;
      POLL: state_d = POLL_WAIT;
      POLL_WAIT: if (i_Bus_Rd_DV) begin
        stat_d = i_Bus_Rd_Data;
        if ((i_Bus_Rd_Data & data_q) == 8'h00) begin
`ifdef BUS8_AUTOCLEAR_HIST_CLEAR_EN
          state_d = HCLR;
`else
          state_d = RESP;
          rsp_data_d = i_Bus_Rd_Data;
          rsp_err_d = 1'b0;
`endif
        end else begin
          pcnt_d = pcnt_q == '1 ? pcnt_q : pcnt_q + PW'(1);
          state_d = pcnt_q < P_LAST ? GAP : STOP;
        end
      end else if (cnt_q == T_LAST) begin
        stat_d = 8'h00;
        state_d = STOP;
      end
      STOP: begin
        state_d = RESP;
        rsp_data_d = stat_q;
        rsp_err_d = 1'b1;
      end
`ifdef BUS8_AUTOCLEAR_HIST_CLEAR_EN
      HCLR: begin
        state_d = RESP;
        rsp_data_d = stat_q;
        rsp_err_d = 1'b0;
      end
`endif
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q == '1 ? cnt_q : cnt_q + CW'(1);
  end
  // State and datapath registers
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pcnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      stat_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pcnt_q <= pcnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      stat_q <= stat_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  // Bus strobe decode: one access per bus state, fields zero when idle
  always_comb begin
    wr = state_q inside {WR, RUN_START, STOP} || hclr;
    o_Bus_CS = wr || state_q inside {RD, POLL};
    o_Bus_Wr_Rd_n = wr;
    o_Bus_Addr8 = state_q inside {WR, RD} ? addr_q : state_q == POLL ? 3'd1 : state_q == STOP ? 3'd2 : hclr ? 3'd4 : 3'd0;
    o_Bus_Wr_Data = wr ? data_q : 8'h00;
  end
  assign o_Cmd_Ready = state_q == IDLE;
  assign o_Rsp_DV = state_q == RESP;
  assign o_Rsp_Data = rsp_data_q;
  assign o_Rsp_Err = rsp_err_q;
endmodule
